apb_uart: RTL and testbench
===========================

Name: apb_uart

Overview:
- UART with 8-bit APB3 slave register interface: a transmitter, a receiver, a 16x-oversampling baud generator, and status/error flags.
- Sits on a peripheral APB bus. TX/RX are serial pins; TXRDY, RXRDY and the error flags are also driven out as level signals for interrupt or GPIO monitoring.
- Two instances connected TX-to-RX form the standard loopback check.

Parameters:
- FIXEDMODE, 0: 1 = line config comes from parameters and control-register writes are ignored; 0 = config is software-programmable.
- BAUD_VALUE, 1: 13-bit baud divisor. Reset/fixed value.
- PRG_BIT8, 1: 1 = 8 data bits, 0 = 7 data bits. Reset/fixed value.
- PRG_PARITY, 0: 2-bit value. 0 = no parity, 1 = even, 2 = odd. 3 is treated as no parity.
- BAUD_VAL_FRCTN, 0: 3-bit fractional divisor, in eighths.
- BAUD_VAL_FRCTN_EN, 0: 1 enables the fractional divisor.

Ports:
- PCLK, in, 1: the single clock.
- PRESETN, in, 1: reset, synchronous, active-low.
- PSEL, in, 1: APB select.
- PENABLE, in, 1: APB enable.
- PWRITE, in, 1: 1 = write.
- PADDR, in, 5: byte address.
- PWDATA, in, 8: write data.
- PRDATA, out, 8: read data.
- PREADY, out, 1: tied 1.
- PSLVERR, out, 1: tied 0.
- TXRDY, out, 1: TX holding register empty.
- RXRDY, out, 1: received byte available.
- PARITY_ERR, out, 1: sticky parity error.
- FRAMING_ERR, out, 1: sticky framing error.
- OVERFLOW, out, 1: sticky overrun.
- RX, in, 1: serial input, idle high.
- TX, out, 1: serial output, idle high.

Behaviour:
- Reset (PRESETN=0 at PCLK rise):
  - TX=1, TXRDY=1, RXRDY=0, PARITY_ERR=0, FRAMING_ERR=0, OVERFLOW=0.
  - Control registers load their parameter values; TX and RX FSMs go to IDLE.
  - Reset mid-frame aborts the frame; TX returns high the next cycle.
- APB timing:
  - Write occurs on PSEL&PENABLE&PWRITE.
  - Read data is combinational while PSEL=1 and PWRITE=0; PRDATA=0 otherwise or for unmapped addresses.
  - No wait states.
- Register map:
  - 0x00 TXDATA (write-only).
  - 0x04 RXDATA (read). In 7-bit mode bit 7 reads 0.
  - 0x08 CTRL1: baud[7:0].
  - 0x0C CTRL2: bit0 BIT8, bit1 PARITY_EN, bit2 ODD_N_EVEN, bits7:3 baud[12:8].
  - 0x10 STATUS (read-only): bit0 TXRDY, bit1 RXRDY, bit2 PARITY_ERR, bit3 OVERFLOW, bit4 FRAMING_ERR, bits7:5 read 0.
  - 0x14 CTRL3: bits2:0 fraction.
  - With FIXEDMODE=1, writes to 0x08, 0x0C and 0x14 are ignored; reads return the parameter-derived values.
- Baud generator:
  - A counter reloads at divisor D and emits a one-cycle tick16 every D+1 PCLK cycles. One bit time = 16 ticks.
  - With fraction F enabled, F out of every 8 consecutive tick16 periods are one PCLK longer.
  - The generator runs continuously; a divisor change takes effect at the next reload.
- Transmit:
  - A TXDATA write with TXRDY=1 loads the holding register; TXRDY=0 from the next cycle.
  - A TXDATA write with TXRDY=0 is ignored.
  - In IDLE with the holding register full, the TX FSM moves it to the shift register and TXRDY returns to 1.
  - FSM states: IDLE, START, DATA (7/8 bits, LSB first), PARITY (if enabled), STOP (1 bit). Each state lasts 16 ticks.
  - Even parity: parity bit = XOR of the data bits. Odd parity: its complement.
  - Back-to-back bytes have no idle gap.
- Receive:
  - RX passes through a 2-FF synchronizer.
  - In IDLE, a low level starts the counter; the start bit is rechecked at tick 8. If RX is high at that check, return to IDLE (glitch).
  - Data, parity and stop bits are sampled at the middle (tick 8) of each bit.
  - At the stop-bit sample the receiver returns to IDLE and the frame completes:
    - RXRDY=0: the byte loads RXDATA and RXRDY=1.
    - RXRDY=1: the byte is discarded, OVERFLOW=1, old data is kept.
    - Parity mismatch: PARITY_ERR=1; the byte is still delivered.
    - Stop bit sampled 0: FRAMING_ERR=1; the byte is still delivered. The receiver waits for RX=1 before arming a new start.
- Read side effect:
  - An RXDATA read (PSEL&PENABLE&!PWRITE, addr 0x04) clears RXRDY, PARITY_ERR, OVERFLOW and FRAMING_ERR at that clock edge.
  - If a new frame completes in the same cycle, its set takes priority.
- Output timing: flag outputs are registered, and equal the STATUS bits.

Test Plan:
- Two instances, DUT1.TX→DUT2.RX, BAUD_VALUE=1, 8 bits, no parity. Write 0x55 to DUT1 0x00 → DUT1 TXRDY drops, DUT2 RXRDY=1 ~10×16×2 cycles later, DUT2 0x04 reads 0x55, RXRDY clears after the read.
- Programmable mode, CTRL2=0x03 (8 bits, parity on, even), send 0xA7 → STATUS=0x03-class (TXRDY|RXRDY), PARITY_ERR=0. Set DUT1 odd and DUT2 even → DUT2 PARITY_ERR=1, STATUS bit2=1, data still 0xA7.
- Send two bytes without reading DUT2 → OVERFLOW=1, RXDATA holds the first byte; one read clears OVERFLOW and RXRDY.
- Force DUT2 RX=0 continuously → FRAMING_ERR=1, RXDATA=0x00, RXRDY=1.
- Write TXDATA twice while TXRDY=0 → the second write is ignored and only two bytes appear on TX (one held, one shifting). Check TX bit period = 16×(D+1) cycles for D=1 and D=5; with FRCTN=4 enabled, check 8 ticks take 8×(D+1)+4 cycles.
- Assert PRESETN=0 mid-frame → TX=1, TXRDY=1, all flags 0 on the next cycle; with FIXEDMODE=1, a CTRL1 write of 0xFF reads back BAUD_VALUE[7:0].

Source files
------------

// File: rtl/apb_uart_if.sv
// apb_uart_if: APB3 bus bundle between a peripheral bus master and the UART register slave
interface apb_uart_if;
    logic       PSEL;
    logic       PENABLE;
    logic       PWRITE;
    logic [4:0] PADDR;
    logic [7:0] PWDATA;
    logic [7:0] PRDATA;
    logic       PREADY;
    logic       PSLVERR;
    modport slave (input PSEL, PENABLE, PWRITE, PADDR, PWDATA, output PRDATA, PREADY, PSLVERR);
    modport master (output PSEL, PENABLE, PWRITE, PADDR, PWDATA, input PRDATA, PREADY, PSLVERR);
endinterface

// File: rtl/apb_uart.sv
// apb_uart: APB3-programmable UART with 16x oversampling baud generator and sticky error flags
module apb_uart #(
    parameter bit          FIXEDMODE         = 1'b0,
    parameter logic [12:0] BAUD_VALUE        = 13'd1,
    parameter bit          PRG_BIT8          = 1'b1,
    parameter logic [1:0]  PRG_PARITY        = 2'd0,
    parameter logic [2:0]  BAUD_VAL_FRCTN    = 3'd0,
    parameter bit          BAUD_VAL_FRCTN_EN = 1'b0
) (
    input  logic      PCLK,
    input  logic      PRESETN,
    apb_uart_if.slave apb,
    input  logic      RX,
    output logic      TX,
    output logic      TXRDY,
    output logic      RXRDY,
    output logic      PARITY_ERR,
    output logic      FRAMING_ERR,
    output logic      OVERFLOW
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
    typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PARITY, R_STOP, R_WAIT} rx_state_t;
    localparam logic PAR_EN0 = (PRG_PARITY == 2'd1) || (PRG_PARITY == 2'd2);
    localparam logic ODD0 = PRG_PARITY == 2'd2;
    logic [12:0] baud;
    logic        bit8, par_en, odd;
    logic [2:0]  frac, frac_cnt;
    logic [13:0] baud_cnt;
    logic        wr, rd_rx, tick;
    tx_state_t   tx_st, tx_nxt;
    logic [7:0]  thr, tx_sh;
    logic        thr_full, tx_par, tx_load, tx_end;
    logic [3:0]  tx_tick;
    logic [2:0]  tx_bit;
    rx_state_t   rx_st, rx_nxt;
    logic        rx_m, rx_s, rx_par, rx_mid, rx_end, rx_done, rx_perr;
    logic [3:0]  rx_tick, rx_bit;
    logic [7:0]  rx_sh, rx_byte, rx_data, rdata;
    logic        rxrdy_q, perr_q, ferr_q, ovf_q;
    assign wr = apb.PSEL && apb.PENABLE && apb.PWRITE;
    assign rd_rx = apb.PSEL && apb.PENABLE && !apb.PWRITE && apb.PADDR == 5'h04;
    assign apb.PREADY = 1'b1;
    assign apb.PSLVERR = 1'b0;
    assign apb.PRDATA = rdata;
    assign tick = baud_cnt == 14'd0;
    assign tx_end = tick && tx_tick == 4'd15;
    assign rx_mid = tick && rx_tick == 4'd7;
    assign rx_end = tick && rx_tick == 4'd15;
    assign rx_byte = bit8 ? rx_sh : {1'b0, rx_sh[7:1]};
    assign rx_perr = par_en && (rx_par ^ (^rx_byte) ^ odd);
    assign TX = tx_st == START ? 1'b0 : tx_st == DATA ? tx_sh[0] : tx_st == PARITY ? tx_par : 1'b1;
    assign TXRDY = !thr_full;
    assign RXRDY = rxrdy_q;
    assign PARITY_ERR = perr_q;
    assign FRAMING_ERR = ferr_q;
    assign OVERFLOW = ovf_q;

    // Line configuration: software-writable unless the build fixes it
    always_ff @(posedge PCLK) begin
        if (!PRESETN) begin
            baud <= BAUD_VALUE; bit8 <= PRG_BIT8; par_en <= PAR_EN0; odd <= ODD0; frac <= BAUD_VAL_FRCTN;
        end else if (wr && !FIXEDMODE) begin
            if (apb.PADDR == 5'h08) baud[7:0] <= apb.PWDATA;
            if (apb.PADDR == 5'h0C) {baud[12:8], odd, par_en, bit8} <= apb.PWDATA;
            if (apb.PADDR == 5'h14) frac <= apb.PWDATA[2:0];
        end
    end

    // Baud divider: reload at the divisor, stretching F of every 8 periods by one cycle
    always_ff @(posedge PCLK) begin
        if (!PRESETN) begin
            baud_cnt <= '0; frac_cnt <= '0;
        end else if (tick) begin
            baud_cnt <= {1'b0, baud} + ((BAUD_VAL_FRCTN_EN && frac_cnt < frac) ? 14'd1 : 14'd0);
            frac_cnt <= frac_cnt + 3'd1;
        end else begin
            baud_cnt <= baud_cnt - 14'd1;
        end
    end

    // TX state register
    always_ff @(posedge PCLK) tx_st <= !PRESETN ? IDLE : tx_nxt;

    // TX next state: take the held byte whenever idle or finishing a stop bit, so frames chain gap-free
    always_comb begin
        tx_nxt = tx_st;
        tx_load = 1'b0;
        case (tx_st)
            IDLE:    if (thr_full) begin tx_nxt = START; tx_load = 1'b1; end
            START:   if (tx_end) tx_nxt = DATA;
            DATA:    if (tx_end && tx_bit == {2'b11, bit8}) tx_nxt = par_en ? PARITY : STOP;
            PARITY:  if (tx_end) tx_nxt = STOP;
            STOP:    if (tx_end) begin tx_nxt = thr_full ? START : IDLE; tx_load = thr_full; end
            default: tx_nxt = IDLE;
        endcase
    end

    // TX holding register, shifter and per-bit tick counter
    always_ff @(posedge PCLK) begin
        if (!PRESETN) begin
            thr <= '0; thr_full <= 1'b0; tx_sh <= '0; tx_par <= 1'b0; tx_tick <= '0; tx_bit <= '0;
        end else begin
            if (wr && apb.PADDR == 5'h00 && !thr_full) begin thr <= apb.PWDATA; thr_full <= 1'b1; end
            if (tx_load) begin
                thr_full <= 1'b0; tx_sh <= thr; tx_par <= ^(thr & {bit8, 7'h7F}) ^ odd;
                tx_tick <= '0; tx_bit <= '0;
            end else begin
                if (tick) tx_tick <= tx_tick + 4'd1;
                if (tx_end && tx_st == DATA) begin tx_sh <= tx_sh >> 1; tx_bit <= tx_bit + 3'd1; end
            end
        end
    end

    // RX state register
    always_ff @(posedge PCLK) rx_st <= !PRESETN ? R_IDLE : rx_nxt;

    // RX next state: recheck the start bit mid-bit, finish the frame at the stop-bit sample
    always_comb begin
        rx_nxt = rx_st;
        rx_done = 1'b0;
        case (rx_st)
            R_IDLE:   if (!rx_s) rx_nxt = R_START;
            R_START:  rx_nxt = (rx_mid && rx_s) ? R_IDLE : rx_end ? R_DATA : R_START;
            R_DATA:   if (rx_end && rx_bit == (bit8 ? 4'd8 : 4'd7)) rx_nxt = par_en ? R_PARITY : R_STOP;
            R_PARITY: if (rx_end) rx_nxt = R_STOP;
            R_STOP:   if (rx_mid) begin rx_done = 1'b1; rx_nxt = rx_s ? R_IDLE : R_WAIT; end
            R_WAIT:   if (rx_s) rx_nxt = R_IDLE;
            default:  rx_nxt = R_IDLE;
        endcase
    end

    // RX synchronizer, oversample counter and mid-bit sampling
    always_ff @(posedge PCLK) begin
        if (!PRESETN) begin
            rx_m <= 1'b1; rx_s <= 1'b1; rx_tick <= '0; rx_bit <= '0; rx_sh <= '0; rx_par <= 1'b0;
        end else begin
            rx_m <= RX; rx_s <= rx_m;
            rx_tick <= rx_st == R_IDLE ? 4'd0 : tick ? rx_tick + 4'd1 : rx_tick;
            if (rx_st == R_IDLE) rx_bit <= '0;
            if (rx_mid && rx_st == R_DATA) begin rx_sh <= {rx_s, rx_sh[7:1]}; rx_bit <= rx_bit + 4'd1; end
            if (rx_mid && rx_st == R_PARITY) rx_par <= rx_s;
        end
    end

    // Receive flags: a completing frame wins over the RXDATA read that clears them
    always_ff @(posedge PCLK) begin
        if (!PRESETN) begin
            rx_data <= '0; rxrdy_q <= 1'b0; perr_q <= 1'b0; ferr_q <= 1'b0; ovf_q <= 1'b0;
        end else begin
            if (rd_rx) begin rxrdy_q <= 1'b0; perr_q <= 1'b0; ferr_q <= 1'b0; ovf_q <= 1'b0; end
            if (rx_done) begin
                if (rxrdy_q && !rd_rx) ovf_q <= 1'b1;
                else begin rx_data <= rx_byte; rxrdy_q <= 1'b1; end
                if (rx_perr) perr_q <= 1'b1;
                if (!rx_s) ferr_q <= 1'b1;
            end
        end
    end

    // Read mux: combinational during a selected read, zero elsewhere
    always_comb begin
        rdata = '0;
        if (apb.PSEL && !apb.PWRITE)
            case (apb.PADDR)
                5'h04:   rdata = {bit8 & rx_data[7], rx_data[6:0]};
                5'h08:   rdata = baud[7:0];
                5'h0C:   rdata = {baud[12:8], odd, par_en, bit8};
                5'h10:   rdata = {3'b000, ferr_q, ovf_q, perr_q, rxrdy_q, !thr_full};
                5'h14:   rdata = {5'b00000, frac};
                default: rdata = '0;
            endcase
    end
endmodule

// File: tb/tb_apb_uart.sv
// tb_apb_uart: loopback scoreboard bench for apb_uart (u1.TX -> u2.RX, u3 fixed-mode with fractional baud)
module tb_apb_uart;
    logic clk = 1'b0, rst_n = 1'b0, brk = 1'b0;
    logic [3:1] sel = '0;
    logic en = 1'b0, wr = 1'b0;
    logic [4:0] addr = '0;
    logic [7:0] wd = '0;
    logic [3:1] txp, txrdy, rxrdy, perr, ferr, ovf;
    logic rx2;
    logic [7:0] rd_now, m_v;
    string qn[$], cn[$];
    logic [7:0] qv[$];
    int ca[$], ce[$];
    string m_nm;
    int m_a, m_e;
    int n_vec = 0, n_err = 0;

    always #5 clk = ~clk;

    apb_uart_if if1(), if2(), if3();
    assign if1.PSEL = sel[1]; assign if1.PENABLE = en; assign if1.PWRITE = wr; assign if1.PADDR = addr; assign if1.PWDATA = wd;
    assign if2.PSEL = sel[2]; assign if2.PENABLE = en; assign if2.PWRITE = wr; assign if2.PADDR = addr; assign if2.PWDATA = wd;
    assign if3.PSEL = sel[3]; assign if3.PENABLE = en; assign if3.PWRITE = wr; assign if3.PADDR = addr; assign if3.PWDATA = wd;
    assign rx2 = txp[1] & !brk;
    assign rd_now = sel[1] ? if1.PRDATA : sel[2] ? if2.PRDATA : if3.PRDATA;

    apb_uart #(.FIXEDMODE(1'b0), .BAUD_VALUE(13'd1)) u1 (
        .PCLK(clk), .PRESETN(rst_n), .apb(if1), .RX(1'b1), .TX(txp[1]), .TXRDY(txrdy[1]), .RXRDY(rxrdy[1]),
        .PARITY_ERR(perr[1]), .FRAMING_ERR(ferr[1]), .OVERFLOW(ovf[1]));
    apb_uart #(.FIXEDMODE(1'b0), .BAUD_VALUE(13'd1)) u2 (
        .PCLK(clk), .PRESETN(rst_n), .apb(if2), .RX(rx2), .TX(txp[2]), .TXRDY(txrdy[2]), .RXRDY(rxrdy[2]),
        .PARITY_ERR(perr[2]), .FRAMING_ERR(ferr[2]), .OVERFLOW(ovf[2]));
    apb_uart #(.FIXEDMODE(1'b1), .BAUD_VALUE(13'd1), .BAUD_VAL_FRCTN(3'd4), .BAUD_VAL_FRCTN_EN(1'b1)) u3 (
        .PCLK(clk), .PRESETN(rst_n), .apb(if3), .RX(1'b1), .TX(txp[3]), .TXRDY(txrdy[3]), .RXRDY(rxrdy[3]),
        .PARITY_ERR(perr[3]), .FRAMING_ERR(ferr[3]), .OVERFLOW(ovf[3]));

    task automatic apb(input int d, input logic w, input logic [4:0] a, input logic [7:0] v);
        sel = '0; sel[d] = 1'b1; wr = w; addr = a; wd = v; en = 1'b0;
        @(posedge clk); #1 en = 1'b1;
        @(posedge clk); #1 sel = '0; en = 1'b0;
    endtask

    task automatic rd(input int d, input logic [4:0] a, input logic [7:0] e, input string nm);
        qn.push_back(nm); qv.push_back(e);
        apb(d, 1'b0, a, 8'h00);
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        cn.push_back(nm); ca.push_back(act); ce.push_back(exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic sig(input int w);
        return w == 0 ? rxrdy[2] : ovf[2];
    endfunction

    task automatic wait_for(input int w, input int budget, input string nm);
        int n = 0;
        while (n < budget && !sig(w)) begin @(posedge clk); #1; n++; end
        chk(nm, int'(sig(w)), 1);
    endtask

    // cycles between two consecutive TX edges after the start-bit falling edge
    task automatic measure(input int d, input int exp, input string nm);
        int n = 0;
        logic prev;
        bit ok = 1'b1;
        while (n < 400 && txp[d] != 1'b0) begin @(posedge clk); #1; n++; end
        ok &= n < 400;
        for (int k = 0; k < 2; k++) begin
            prev = txp[d]; n = 0;
            while (n < 400 && txp[d] == prev) begin @(posedge clk); #1; n++; end
            ok &= n < 400;
        end
        chk(nm, ok ? n : -1, exp);
    endtask

    // scoreboard monitor: compares APB read data and queued level checks
    always @(negedge clk) begin
        while (ca.size() != 0) begin
            m_nm = cn.pop_front(); m_a = ca.pop_front(); m_e = ce.pop_front();
            n_vec++;
            if (m_a != m_e) begin n_err++; $display("FAIL %s: got %0d, required %0d", m_nm, m_a, m_e); end
        end
        if (en && !wr && sel != '0) begin
            n_vec++;
            if (qv.size() == 0) begin
                n_err++; $display("FAIL unexpected_read: got %h, required none", rd_now);
            end else begin
                m_nm = qn.pop_front(); m_v = qv.pop_front();
                if (rd_now !== m_v) begin n_err++; $display("FAIL %s: got %h, required %h", m_nm, rd_now, m_v); end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle(3);
        rst_n = 1'b1;
        idle(2);
        chk("rst_tx", int'(txp[1]), 1);
        chk("rst_txrdy", int'(txrdy[1]), 1);
        chk("rst_rxrdy", int'(rxrdy[2]), 0);
        chk("rst_perr", int'(perr[2]), 0);
        chk("rst_ferr", int'(ferr[2]), 0);
        chk("rst_ovf", int'(ovf[2]), 0);
        rd(1, 5'h10, 8'h01, "rst_status");
        rd(1, 5'h18, 8'h00, "unmapped_read");
        rd(1, 5'h00, 8'h00, "txdata_read");
        // basic loopback, D=1
        apb(1, 1'b1, 5'h00, 8'h55);
        chk("txrdy_drop", int'(txrdy[1]), 0);
        measure(1, 32, "bit_period_d1");
        wait_for(0, 1000, "rx_done_55");
        rd(2, 5'h04, 8'h55, "rxdata_55");
        chk("rxrdy_cleared", int'(rxrdy[2]), 0);
        // even parity on both ends
        apb(1, 1'b1, 5'h0C, 8'h03);
        apb(2, 1'b1, 5'h0C, 8'h03);
        apb(1, 1'b1, 5'h00, 8'hA7);
        wait_for(0, 1000, "rx_done_a7_even");
        chk("perr_even_ok", int'(perr[2]), 0);
        rd(2, 5'h10, 8'h03, "status_even");
        rd(2, 5'h04, 8'hA7, "rxdata_a7_even");
        // sender odd, receiver even
        apb(1, 1'b1, 5'h0C, 8'h07);
        apb(1, 1'b1, 5'h00, 8'hA7);
        wait_for(0, 1000, "rx_done_a7_odd");
        chk("perr_set", int'(perr[2]), 1);
        rd(2, 5'h10, 8'h07, "status_perr");
        rd(2, 5'h04, 8'hA7, "rxdata_a7_perr");
        rd(2, 5'h10, 8'h01, "status_perr_cleared");
        // overflow and ignored write while busy
        apb(1, 1'b1, 5'h0C, 8'h01);
        apb(2, 1'b1, 5'h0C, 8'h01);
        idle(100);
        apb(1, 1'b1, 5'h00, 8'h11);
        apb(1, 1'b1, 5'h00, 8'h22);
        apb(1, 1'b1, 5'h00, 8'h44);
        chk("txrdy_busy", int'(txrdy[1]), 0);
        wait_for(0, 1000, "rx_done_11");
        wait_for(1, 1000, "ovf_set");
        rd(2, 5'h10, 8'h0B, "status_ovf");
        rd(2, 5'h04, 8'h11, "rxdata_kept_first");
        rd(2, 5'h10, 8'h01, "status_ovf_cleared");
        idle(500);
        chk("no_third_byte", int'(rxrdy[2]), 0);
        chk("txrdy_back", int'(txrdy[1]), 1);
        // divisor 5
        apb(1, 1'b1, 5'h08, 8'h05);
        apb(2, 1'b1, 5'h08, 8'h05);
        rd(1, 5'h08, 8'h05, "ctrl1_readback");
        rd(1, 5'h0C, 8'h01, "ctrl2_readback");
        apb(1, 1'b1, 5'h00, 8'h55);
        measure(1, 96, "bit_period_d5");
        wait_for(0, 3000, "rx_done_d5");
        rd(2, 5'h04, 8'h55, "rxdata_d5");
        // fixed mode with fraction 4/8 on u3
        apb(3, 1'b1, 5'h00, 8'h55);
        measure(3, 40, "bit_period_frac");
        apb(3, 1'b1, 5'h08, 8'hFF);
        apb(3, 1'b1, 5'h0C, 8'hFF);
        apb(3, 1'b1, 5'h14, 8'h07);
        rd(3, 5'h08, 8'h01, "fixed_ctrl1");
        rd(3, 5'h0C, 8'h01, "fixed_ctrl2");
        rd(3, 5'h14, 8'h04, "fixed_ctrl3");
        // framing error: RX held low
        idle(200);
        brk = 1'b1;
        wait_for(0, 3000, "rx_done_break");
        chk("ferr_set", int'(ferr[2]), 1);
        rd(2, 5'h10, 8'h13, "status_ferr");
        rd(2, 5'h04, 8'h00, "rxdata_break");
        chk("ferr_cleared", int'(ferr[2]), 0);
        brk = 1'b0;
        // reset in the middle of a frame
        idle(50);
        apb(1, 1'b1, 5'h00, 8'h00);
        wait_for(0, 3000, "rx_done_00");
        idle(100);
        apb(1, 1'b1, 5'h00, 8'h00);
        idle(200);
        chk("tx_midframe", int'(txp[1]), 0);
        apb(1, 1'b1, 5'h00, 8'h00);
        chk("txrdy_held", int'(txrdy[1]), 0);
        @(negedge clk) rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midrst_tx", int'(txp[1]), 1);
        chk("midrst_txrdy", int'(txrdy[1]), 1);
        chk("midrst_rxrdy", int'(rxrdy[2]), 0);
        chk("midrst_flags", int'({perr[2], ferr[2], ovf[2]}), 0);
        idle(1);
        rst_n = 1'b1;
        idle(2);
        chk("scoreboard_drained", qv.size(), 0);
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
